// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: pulses the PLL reset and waits for a stable lock.
// It then releases three staged system resets in order, bit 0 first.
// If lock is lost after release has begun, it drops every stage and restarts.
// Ports:
//   clk, reset_n    free-running reference clock, async active-low reset
//   pll_locked      PLL lock flag (asynchronous, synchronized internally)
//   lock_lost_clr   synchronous clear for the sticky lock_lost flag
//   pll_rst         active-high PLL reset
//   sys_reset_n     staged active-low resets, bit 0 released first
//   ready           all stages released and lock held
//   lock_lost       sticky: lock dropped after release had begun
//   retry_cnt       number of lock timeouts, saturating at 255
module pll_reset_sequencer #(
  parameter int unsigned PLL_RST_CYCLES      = 16,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned STAGE_GAP_CYCLES    = 64
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pll_locked,
  input  logic       lock_lost_clr,
  output logic       pll_rst,
  output logic [2:0] sys_reset_n,
  output logic       ready,
  output logic       lock_lost,
  output logic [7:0] retry_cnt
);

  localparam int unsigned CNT_W   = 24;
  localparam int unsigned STAGE_W = 3;
  localparam int unsigned RETRY_W = 8;

  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(STAGE_GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_PLL_RST,
    S_WAIT_LOCK,
    S_STABLE,
    S_RELEASE,
    S_RUN
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 sync1_q, sync2_q;
  logic                 pll_rst_q, pll_rst_d;
  logic [STAGE_W-1:0]   sys_q, sys_d;
  logic                 ready_q, ready_d;
  logic                 lost_q, lost_d;
  logic                 lost_set;
  logic [RETRY_W-1:0]   retry_q, retry_d;
  logic                 locked_s;

  // Two-flop synchronizer for the asynchronous lock flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= pll_locked;
      sync2_q <= sync1_q;
    end
  end

  assign locked_s = sync2_q;

  // State, shared counter and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_PLL_RST;
      cnt_q     <= '0;
      pll_rst_q <= 1'b1;
      sys_q     <= '0;
      ready_q   <= 1'b0;
      lost_q    <= 1'b0;
      retry_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pll_rst_q <= pll_rst_d;
      sys_q     <= sys_d;
      ready_q   <= ready_d;
      lost_q    <= lost_d;
      retry_q   <= retry_d;
    end
  end

  // Next state; outputs are computed for the state being entered so the
  // registered outputs line up with the registered state.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CNT_W'(1);
    pll_rst_d = pll_rst_q;
    sys_d     = sys_q;
    ready_d   = ready_q;
    retry_d   = retry_q;
    lost_set  = 1'b0;

    case (state_q)
      S_PLL_RST: begin
        if (cnt_q == RST_LAST) begin
          state_d   = S_WAIT_LOCK;
          cnt_d     = '0;
          pll_rst_d = 1'b0;
        end
      end
      S_WAIT_LOCK: begin
        if (locked_s) begin
          state_d = S_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == TMO_LAST) begin
          state_d   = S_PLL_RST;
          cnt_d     = '0;
          pll_rst_d = 1'b1;
          if (retry_q != '1) begin
            retry_d = retry_q + RETRY_W'(1);
          end
        end
      end
      S_STABLE: begin
        // Any low sample restarts the stability window
        if (!locked_s) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STB_LAST) begin
          state_d = S_RELEASE;
          cnt_d   = '0;
          sys_d   = 3'b001;
        end
      end
      S_RELEASE: begin
        if (!locked_s) begin
          lost_set = 1'b1;
        end else if (cnt_q == GAP_LAST) begin
          // Counter restarts per stage gap so it never needs 2x range
          cnt_d = '0;
          if (sys_q[1]) begin
            state_d = S_RUN;
            sys_d   = 3'b111;
            ready_d = 1'b1;
          end else begin
            sys_d = 3'b011;
          end
        end
      end
      S_RUN: begin
        cnt_d = cnt_q;
        if (!locked_s) begin
          lost_set = 1'b1;
        end
      end
      default: begin
        state_d   = S_PLL_RST;
        cnt_d     = '0;
        pll_rst_d = 1'b1;
        sys_d     = '0;
        ready_d   = 1'b0;
      end
    endcase

    // Lock loss after release began: drop everything and re-lock
    if (lost_set) begin
      state_d   = S_PLL_RST;
      cnt_d     = '0;
      pll_rst_d = 1'b1;
      sys_d     = '0;
      ready_d   = 1'b0;
    end
  end

  // Sticky flag; a set in the same cycle as a clear wins
  always_comb begin
    lost_d = lost_q;
    if (lost_set) begin
      lost_d = 1'b1;
    end else if (lock_lost_clr) begin
      lost_d = 1'b0;
    end
  end

  assign pll_rst     = pll_rst_q;
  assign sys_reset_n = sys_q;
  assign ready       = ready_q;
  assign lock_lost   = lost_q;
  assign retry_cnt   = retry_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench for pll_reset_sequencer with short timing parameters.
// A phase/elapsed-time reference model predicts every output each cycle.
module tb_pll_reset_sequencer;

  localparam int P_RST = 4;
  localparam int P_TMO = 32;
  localparam int P_STB = 8;
  localparam int P_GAP = 4;

  localparam int PH_RST  = 0;
  localparam int PH_WAIT = 1;
  localparam int PH_STB  = 2;
  localparam int PH_REL  = 3;
  localparam int PH_RUN  = 4;

  logic       clk;
  logic       reset_n;
  logic       pll_locked;
  logic       lock_lost_clr;
  logic       pll_rst;
  logic [2:0] sys_reset_n;
  logic       ready;
  logic       lock_lost;
  logic [7:0] retry_cnt;

  int n_cmp;
  int n_bad;

  // Reference model state
  int   m_phase;
  int   m_t;
  logic m_s1;
  logic m_s2;
  logic m_lost;
  int   m_retry;

  pll_reset_sequencer #(
    .PLL_RST_CYCLES     (P_RST),
    .LOCK_TIMEOUT_CYCLES(P_TMO),
    .LOCK_STABLE_CYCLES (P_STB),
    .STAGE_GAP_CYCLES   (P_GAP)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .pll_locked   (pll_locked),
    .lock_lost_clr(lock_lost_clr),
    .pll_rst      (pll_rst),
    .sys_reset_n  (sys_reset_n),
    .ready        (ready),
    .lock_lost    (lock_lost),
    .retry_cnt    (retry_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = PH_RST;
    m_t     = 0;
    m_s1    = 1'b0;
    m_s2    = 1'b0;
    m_lost  = 1'b0;
    m_retry = 0;
  endtask

  // One clock edge of the reference behaviour, using the inputs seen at that edge
  task automatic model_edge(input logic pl, input logic clr);
    logic ls;
    logic set;
    ls   = m_s2;
    set  = 1'b0;
    m_s2 = m_s1;
    m_s1 = pl;
    case (m_phase)
      PH_RST: begin
        m_t++;
        if (m_t == P_RST) begin m_phase = PH_WAIT; m_t = 0; end
      end
      PH_WAIT: begin
        if (ls) begin
          m_phase = PH_STB; m_t = 0;
        end else begin
          m_t++;
          if (m_t == P_TMO) begin
            m_phase = PH_RST; m_t = 0;
            if (m_retry < 255) m_retry++;
          end
        end
      end
      PH_STB: begin
        if (!ls) begin
          m_phase = PH_WAIT; m_t = 0;
        end else begin
          m_t++;
          if (m_t == P_STB) begin m_phase = PH_REL; m_t = 0; end
        end
      end
      PH_REL, PH_RUN: begin
        if (!ls) begin
          m_phase = PH_RST; m_t = 0; set = 1'b1;
        end else if (m_phase == PH_REL) begin
          m_t++;
          if (m_t == 2 * P_GAP) m_phase = PH_RUN;
        end
      end
      default: m_phase = PH_RST;
    endcase
    if (set) m_lost = 1'b1;
    else if (clr) m_lost = 1'b0;
  endtask

  // Expected {pll_rst, sys_reset_n, ready, lock_lost, retry_cnt}
  function automatic logic [13:0] model_out();
    logic [2:0] sys;
    sys = 3'b000;
    if (m_phase == PH_REL) sys = (m_t < P_GAP) ? 3'b001 : 3'b011;
    else if (m_phase == PH_RUN) sys = 3'b111;
    return {(m_phase == PH_RST), sys, (m_phase == PH_RUN), m_lost, 8'(m_retry)};
  endfunction

  function automatic logic [13:0] dut_out();
    return {pll_rst, sys_reset_n, ready, lock_lost, retry_cnt};
  endfunction

  // Drive inputs, take one edge, then compare at the falling edge
  task automatic step(input logic pl, input logic clr);
    pll_locked    = pl;
    lock_lost_clr = clr;
    @(posedge clk);
    model_edge(pl, clr);
    @(negedge clk);
    chk("outputs", 32'(dut_out()), 32'(model_out()));
  endtask

  task automatic apply_reset();
    reset_n       = 1'b0;
    pll_locked    = 1'b0;
    lock_lost_clr = 1'b0;
    model_reset();
    repeat (2) begin
      @(negedge clk);
      chk("reset_vals", 32'(dut_out()), 32'(model_out()));
    end
    reset_n = 1'b1;
  endtask

  initial begin
    int hi_cnt;
    int t001, t011, t111;
    int rise1, rise2;
    logic prev_rst;
    logic pl_r;
    int run;
    bit found;

    n_cmp = 0;
    n_bad = 0;
    reset_n = 1'b0;
    pll_locked = 1'b0;
    lock_lost_clr = 1'b0;
    model_reset();

    // Reset values, then lock held from release: nominal bring-up
    apply_reset();
    chk("rst_pll_rst", 32'(pll_rst), 32'd1);
    hi_cnt = 0; t001 = -1; t011 = -1; t111 = -1;
    for (int i = 1; i <= 30; i++) begin
      if (pll_rst) hi_cnt++;
      step(1'b1, 1'b0);
      if (sys_reset_n == 3'b001 && t001 < 0) t001 = i;
      if (sys_reset_n == 3'b011 && t011 < 0) t011 = i;
      if (sys_reset_n == 3'b111 && ready && t111 < 0) t111 = i;
    end
    chk("pll_rst_width", 32'(hi_cnt), 32'(P_RST));
    chk("bit0_release", 32'(t001), 32'd13);
    chk("bit1_gap", 32'(t011 - t001), 32'(P_GAP));
    chk("bit2_gap_ready", 32'(t111 - t011), 32'(P_GAP));
    chk("retry_zero", 32'(retry_cnt), 32'd0);

    // One-cycle dropout at stability count 5 restarts the window
    apply_reset();
    hi_cnt = 0; t111 = -1;
    for (int i = 1; i <= 34; i++) begin
      step((i == 9) ? 1'b0 : 1'b1, 1'b0);
      if (i > 4 && pll_rst) hi_cnt++;
      if (ready && t111 < 0) t111 = i;
    end
    chk("glitch_no_pll_rst", 32'(hi_cnt), 32'd0);
    chk("glitch_ready_time", 32'(t111), 32'd28);

    // Lock drop in RUN with a clear on the same edge; set must win
    repeat (3) step(1'b0, 1'b1);
    chk("lost_set_wins", 32'(lock_lost), 32'd1);
    chk("lost_drop_sys", 32'({sys_reset_n, ready}), 32'd0);
    repeat (3) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    chk("lost_cleared", 32'(lock_lost), 32'd0);
    repeat (10) step(1'b1, 1'b0);

    // Asynchronous reset while sys_reset_n = 011
    apply_reset();
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step(1'b1, 1'b0);
      if (sys_reset_n == 3'b011) found = 1'b1;
    end
    chk("reached_011", 32'(found), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_sys", 32'(sys_reset_n), 32'd0);
    chk("async_pll_rst", 32'(pll_rst), 32'd1);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;

    // No lock for 200 cycles: periodic pll_rst pulses and retries
    rise1 = -1; rise2 = -1;
    prev_rst = pll_rst;
    for (int i = 1; i <= 200; i++) begin
      step(1'b0, 1'b0);
      if (pll_rst && !prev_rst) begin
        if (rise1 < 0) rise1 = i;
        else if (rise2 < 0) rise2 = i;
      end
      prev_rst = pll_rst;
    end
    chk("first_timeout", 32'(rise1), 32'd36);
    chk("retry_period", 32'(rise2 - rise1), 32'd36);
    chk("retry_after_200", 32'(retry_cnt), 32'd5);

    // Long no-lock run: retry counter saturates
    for (int i = 0; i < 300 * 36; i++) step(1'b0, 1'b0);
    chk("retry_saturated", 32'(retry_cnt), 32'd255);

    // Randomized lock waveform and clear pulses
    apply_reset();
    run = 0;
    pl_r = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (run == 0) begin
        pl_r = ($urandom_range(0, 3) != 0);
        run  = $urandom_range(1, 80);
      end
      run--;
      step(pl_r, ($urandom_range(0, 9) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
